// File: rtl/fwd_pkg.sv
// Shared types and defaults for the forwarding mux pipeline: buffer state encoding,
// default widths and the select-width helper.
package fwd_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NUM_SRC = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  // A single source bit is still needed when NUM_SRC is 2.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_nto1.sv
// Combinational N-to-1 operand selector; out-of-range selects fall back to source 0.
// Zero latency, no flow control.
module mux_nto1
  import fwd_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_SRC = DEF_NUM_SRC,
  localparam int SEL_W  = sel_width(NUM_SRC)
) (
  input  logic [NUM_SRC*DATA_W-1:0] i_data,
  input  logic [SEL_W-1:0]          i_sel,
  output logic [DATA_W-1:0]         o_data
);

  always_comb begin
    o_data = i_data[DATA_W-1:0];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_data = i_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/fwd_mux_pipe.sv
// Operand select feeding a 2-entry skid buffer: 1-cycle latency, in_ready drops (registered)
// when both entries are held. Optional sticky bad-select flag under FWD_MUX_SEL_ERR_EN.
module fwd_mux_pipe
  import fwd_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_SRC = DEF_NUM_SRC,
  localparam int SEL_W  = sel_width(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      flush,
  output logic                      sel_err
);

  buf_state_t        r_state;
  buf_state_t        w_state_nxt;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_skid;
  logic              r_in_rdy;
  logic [DATA_W-1:0] w_sel_dat;
  logic              w_push;
  logic              w_pop;

  mux_nto1 #(
    .DATA_W  (DATA_W),
    .NUM_SRC (NUM_SRC)
  ) u_mux (
    .i_data (in_data),
    .i_sel  (in_sel),
    .o_data (w_sel_dat)
  );

  // A push coinciding with flush is dropped, so it never counts as accepted.
  assign w_push    = in_valid & r_in_rdy & ~flush;
  assign w_pop     = out_valid & out_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_head;
  assign in_ready  = r_in_rdy;

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
        ST_ONE: begin
          if (w_push && !w_pop)      w_state_nxt = ST_TWO;
          else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
        end
        ST_TWO:   if (w_pop) w_state_nxt = ST_ONE;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_EMPTY;
      r_in_rdy <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_in_rdy <= (w_state_nxt != ST_TWO);
    end
  end

  // Head always holds the oldest entry; the skid slot only fills while head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_skid <= '0;
    end else if (!flush) begin
      case (r_state)
        ST_EMPTY: if (w_push) r_head <= w_sel_dat;
        ST_ONE: begin
          if (w_push && w_pop) r_head <= w_sel_dat;
          else if (w_push)     r_skid <= w_sel_dat;
        end
        ST_TWO:   if (w_pop) r_head <= r_skid;
        default:  ;
      endcase
    end
  end

`ifdef FWD_MUX_SEL_ERR_EN
  localparam logic [SEL_W:0] LP_NUM_SRC = (SEL_W+1)'(NUM_SRC);
  logic r_sel_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else if (w_push && ({1'b0, in_sel} >= LP_NUM_SRC)) begin
      r_sel_err <= 1'b1;
    end
  end

  assign sel_err = r_sel_err;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_fwd_mux_pipe.sv
// Bench for fwd_mux_pipe: three parameterisations sharing one clock; the 32x3 instance is
// tracked against a queue model of the buffer, the others with directed passthrough.
module tb_fwd_mux_pipe;

`ifdef FWD_MUX_SEL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [95:0] a_in_data;
  logic [1:0]  a_sel;
  logic        a_vld, a_rdy, a_ordy, a_ovld, a_flush, a_err;
  logic [31:0] a_out;

  logic [319:0] b_in_data;
  logic [2:0]   b_sel;
  logic         b_vld, b_rdy, b_ordy, b_ovld, b_flush, b_err;
  logic [63:0]  b_out;

  logic [63:0] c_in_data;
  logic [0:0]  c_sel;
  logic        c_vld, c_rdy, c_ordy, c_ovld, c_flush, c_err;
  logic [31:0] c_out;

  fwd_mux_pipe #(.DATA_W(32), .NUM_SRC(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_sel(a_sel), .in_valid(a_vld),
    .in_ready(a_rdy), .out_data(a_out), .out_valid(a_ovld), .out_ready(a_ordy),
    .flush(a_flush), .sel_err(a_err));

  fwd_mux_pipe #(.DATA_W(64), .NUM_SRC(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_sel), .in_valid(b_vld),
    .in_ready(b_rdy), .out_data(b_out), .out_valid(b_ovld), .out_ready(b_ordy),
    .flush(b_flush), .sel_err(b_err));

  fwd_mux_pipe #(.DATA_W(32), .NUM_SRC(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_sel(c_sel), .in_valid(c_vld),
    .in_ready(c_rdy), .out_data(c_out), .out_valid(c_ovld), .out_ready(c_ordy),
    .flush(c_flush), .sel_err(c_err));

  int checks = 0;
  int failures = 0;

  // Reference model for dut_a: FIFO contents, whether the block is accepting, sticky error.
  logic [31:0] mq[$];
  bit          m_rdy = 1'b0;
  bit          m_err = 1'b0;

  function automatic logic [31:0] sel_ref(input logic [95:0] d, input logic [1:0] s);
    if (s < 2'd3) return d[s*32 +: 32];
    return d[31:0];
  endfunction

  function automatic logic [31:0] m_head();
    if (mq.size() == 0) return 32'h0;
    return mq[0];
  endfunction

  // Advance one clock edge and update the model with the inputs present at that edge.
  task automatic tick();
    bit          push, pop;
    logic [31:0] v;
    push = a_vld && m_rdy && !a_flush;
    pop  = (mq.size() != 0) && a_ordy;
    v    = sel_ref(a_in_data, a_sel);
    @(posedge clk);
    if (a_flush) begin
      mq.delete();
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(v);
    end
    if (push && a_sel == 2'd3 && ERR_EN) m_err = 1'b1;
    m_rdy = (mq.size() < 2);
    #1;
  endtask

  task automatic idle_all();
    a_vld = 0; a_ordy = 0; a_flush = 0; a_sel = 0; a_in_data = '0;
    b_vld = 0; b_ordy = 0; b_flush = 0; b_sel = 0; b_in_data = '0;
    c_vld = 0; c_ordy = 0; c_flush = 0; c_sel = 0; c_in_data = '0;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    #3;
    checks++;
    if (a_ovld !== 1'b0 || a_rdy !== 1'b0 || a_out !== 32'h0 || a_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_a: vld=%b rdy=%b dat=%h err=%b want 0 0 0 0", a_ovld, a_rdy, a_out, a_err);
    end
    checks++;
    if (b_ovld !== 1'b0 || b_rdy !== 1'b0 || c_ovld !== 1'b0 || c_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_bc: b %b/%b c %b/%b want all 0", b_ovld, b_rdy, c_ovld, c_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); m_rdy = 0; m_err = 0;
    tick();
    checks++;
    if (a_rdy !== 1'b1 || a_ovld !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: rdy=%b vld=%b want 1 0", a_rdy, a_ovld);
    end
  endtask

  task automatic drain();
    a_vld = 0; a_flush = 0; a_ordy = 1;
    tick(); tick();
    a_ordy = 0;
  endtask

  task automatic test_passthrough();
    logic [31:0] cval;
    drain();
    a_ordy = 1; a_vld = 1; a_sel = 2'd2;
    for (int i = 0; i < 6; i++) begin
      cval = $urandom;
      a_in_data = {cval, 32'hBBBB_0000 + i, 32'hAAAA_0000 + i};
      tick();
      checks++;
      if (a_ovld !== 1'b1 || a_out !== cval || a_rdy !== 1'b1) begin
        failures++;
        $display("FAIL passthrough[%0d]: vld=%b dat=%h rdy=%b want 1 %h 1", i, a_ovld, a_out, a_rdy, cval);
      end
    end
    a_vld = 0;
  endtask

  task automatic test_backpressure();
    drain();
    a_ordy = 0; a_vld = 1; a_sel = 2'd0;
    a_in_data = {32'h0, 32'h0, 32'h11};
    tick();
    a_in_data = {32'h0, 32'h0, 32'h22};
    tick();
    a_vld = 0;
    checks++;
    if (a_rdy !== 1'b0 || a_ovld !== 1'b1 || a_out !== 32'h11) begin
      failures++;
      $display("FAIL bp_full: rdy=%b vld=%b dat=%h want 0 1 00000011", a_rdy, a_ovld, a_out);
    end
    tick();
    checks++;
    if (a_out !== 32'h11 || a_rdy !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold: dat=%h rdy=%b want 00000011 0", a_out, a_rdy);
    end
    a_ordy = 1;
    tick();
    checks++;
    if (a_ovld !== 1'b1 || a_out !== 32'h22 || a_rdy !== 1'b1) begin
      failures++;
      $display("FAIL bp_second: vld=%b dat=%h rdy=%b want 1 00000022 1", a_ovld, a_out, a_rdy);
    end
    tick();
    checks++;
    if (a_ovld !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty: vld=%b want 0", a_ovld);
    end
  endtask

  task automatic test_flush();
    drain();
    a_ordy = 0; a_vld = 1; a_sel = 2'd1;
    a_in_data = {32'h3, 32'h101, 32'h1};
    tick();
    a_in_data = {32'h3, 32'h202, 32'h1};
    tick();
    checks++;
    if (a_rdy !== 1'b0) begin
      failures++;
      $display("FAIL flush_pre: rdy=%b want 0", a_rdy);
    end
    a_flush = 1; a_in_data = {32'h3, 32'h303, 32'h1};
    tick();
    a_flush = 0; a_vld = 0;
    checks++;
    if (a_ovld !== 1'b0 || a_rdy !== 1'b1) begin
      failures++;
      $display("FAIL flush: vld=%b rdy=%b want 0 1", a_ovld, a_rdy);
    end
    a_ordy = 1;
    tick();
    checks++;
    if (a_ovld !== 1'b0) begin
      failures++;
      $display("FAIL flush_discard: vld=%b dat=%h want empty", a_ovld, a_out);
    end
  endtask

  task automatic test_out_of_range();
    drain();
    a_ordy = 1; a_vld = 1; a_sel = 2'd3;
    a_in_data = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'h5A5A_0003};
    tick();
    a_vld = 0;
    checks++;
    if (a_ovld !== 1'b1 || a_out !== 32'h5A5A_0003) begin
      failures++;
      $display("FAIL oor_data: vld=%b dat=%h want 1 5a5a0003", a_ovld, a_out);
    end
    checks++;
    if (a_err !== ERR_EN) begin
      failures++;
      $display("FAIL oor_err: sel_err=%b want %b", a_err, ERR_EN);
    end
    tick();
    checks++;
    if (a_err !== ERR_EN) begin
      failures++;
      $display("FAIL oor_sticky: sel_err=%b want %b", a_err, ERR_EN);
    end
  endtask

  task automatic test_async_reset();
    drain();
    a_ordy = 0; a_vld = 1; a_sel = 2'd0;
    a_in_data = {32'h0, 32'h0, 32'h1234_5678};
    tick();
    a_vld = 0;
    checks++;
    if (a_ovld !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre: vld=%b want 1", a_ovld);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_ovld !== 1'b0 || a_out !== 32'h0 || a_rdy !== 1'b0 || a_err !== 1'b0) begin
      failures++;
      $display("FAIL areset_now: vld=%b dat=%h rdy=%b err=%b want 0 0 0 0", a_ovld, a_out, a_rdy, a_err);
    end
    #2 rst_n = 1'b1;
    mq.delete(); m_rdy = 0; m_err = 0;
    tick();
    a_vld = 1; a_ordy = 1; a_in_data = {32'h0, 32'h0, 32'hDEAD_BEEF};
    tick();
    a_vld = 0;
    checks++;
    if (a_ovld !== 1'b1 || a_out !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL areset_after: vld=%b dat=%h want 1 deadbeef", a_ovld, a_out);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      a_vld     = ($urandom_range(0, 3) != 0);
      a_ordy    = ($urandom_range(0, 2) != 0);
      a_flush   = ($urandom_range(0, 15) == 0);
      a_sel     = 2'($urandom_range(0, 3));
      a_in_data = {$urandom, $urandom, $urandom};
      tick();
      checks++;
      if (a_ovld !== (mq.size() != 0) || a_rdy !== m_rdy || a_err !== m_err ||
          (mq.size() != 0 && a_out !== m_head())) begin
        failures++;
        bad++;
        if (bad < 10)
          $display("FAIL random[%0d]: vld=%b rdy=%b dat=%h err=%b want %b %b %h %b", i, a_ovld,
                   a_rdy, a_out, a_err, mq.size() != 0, m_rdy, m_head(), m_err);
      end
    end
    idle_all();
  endtask

  task automatic test_sweep();
    logic [63:0] s4;
    logic [31:0] s1;
    b_vld = 1; b_ordy = 1; b_sel = 3'd4;
    c_vld = 1; c_ordy = 1; c_sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s4 = {$urandom, $urandom};
      s1 = $urandom;
      b_in_data = {s4, 64'h3333_3333_0000_0003, 64'h2, 64'h1, {$urandom, $urandom}};
      c_in_data = {s1, $urandom};
      tick();
      checks++;
      if (b_ovld !== 1'b1 || b_out !== s4 || b_rdy !== 1'b1) begin
        failures++;
        $display("FAIL sweep_b[%0d]: vld=%b dat=%h rdy=%b want 1 %h 1", i, b_ovld, b_out, b_rdy, s4);
      end
      checks++;
      if (c_ovld !== 1'b1 || c_out !== s1 || c_rdy !== 1'b1) begin
        failures++;
        $display("FAIL sweep_c[%0d]: vld=%b dat=%h rdy=%b want 1 %h 1", i, c_ovld, c_out, c_rdy, s1);
      end
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_backpressure();
    test_flush();
    test_out_of_range();
    test_async_reset();
    test_random();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_mux_pipe.md
FWD_MUX_PIPE -- requirements
Module: fwd_mux_pipe

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning operand width in bits.
REQ-002 SHALL provide parameter NUM_SRC, default 3, meaning number of selectable sources (≥2).
REQ-003 SHALL provide derived localparam SEL_W = max(1, clog2(NUM_SRC)), meaning select width.
REQ-004 SHALL provide port clk  input  1  rising-edge clock; one clock, all state on it.
REQ-005 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL provide port in_data  input  NUM_SRC*DATA_W  packed sources; source k at bits [k*DATA_W +: DATA_W].
REQ-007 SHALL provide port in_sel  input  SEL_W  source index, sampled with in_valid.
REQ-008 SHALL provide port in_valid  input  1  upstream offers a transfer.
REQ-009 SHALL provide port in_ready  output  1  block accepts a transfer; registered.
REQ-010 SHALL provide port out_data  output  DATA_W  selected operand, driven from the buffer head.
REQ-011 SHALL provide port out_valid  output  1  out_data is valid.
REQ-012 SHALL provide port out_ready  input  1  downstream consumes out_data.
REQ-013 SHALL provide port flush  input  1  synchronous discard of all buffered entries.
REQ-014 SHALL provide port sel_err  output  1  sticky out-of-range-select flag (see Configuration).

Function
REQ-015 SHALL complete an input transfer when in_valid && in_ready and an output transfer when out_valid && out_ready, both at the clk rising edge.
REQ-016 SHALL select source in_sel when in_sel < NUM_SRC, and source 0 otherwise; the selection SHALL be combinational and free of latches.
REQ-017 SHALL store selected data in a 2-entry skid buffer with states EMPTY, ONE and TWO.
REQ-018 SHALL have 1-cycle latency: data accepted at edge N SHALL appear on out_data with out_valid=1 after edge N.
REQ-019 SHALL transition as follows: EMPTY+push→ONE; ONE+push-only→TWO; ONE+pop-only→EMPTY; ONE+push+pop→ONE; TWO+pop→ONE; all other cases hold state.
REQ-020 SHALL drive in_ready = (state != TWO), updated only at clock edges.
REQ-021 SHALL preserve order: out_data SHALL always be the oldest unconsumed entry.
REQ-022 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on flush=1, go to EMPTY at that edge, ignore any simultaneous push, and assert in_ready=1 in the next cycle.
REQ-024 SHALL sustain one transfer per cycle when out_ready stays high.

Reset
REQ-025 SHALL, while rst_n=0, immediately force state=EMPTY, out_valid=0, in_ready=0, out_data=0 and sel_err=0.
REQ-026 SHALL drive in_ready=1 from the first rising edge after rst_n deasserts; reset asserted mid-transfer SHALL discard all entries.

Configuration
REQ-027 SHALL define macro FWD_MUX_SEL_ERR_EN: when defined, a push with in_sel ≥ NUM_SRC SHALL set sel_err=1, cleared only by reset.
REQ-028 SHALL, when FWD_MUX_SEL_ERR_EN is undefined, tie sel_err to 0 and include no error logic; the data path SHALL be identical in both builds.

Structure
REQ-029 SHALL place the state encoding (EMPTY/ONE/TWO typedef) and the DATA_W/NUM_SRC defaults in the shared package fwd_pkg.
REQ-030 SHALL implement the combinational selector as sub-module mux_nto1 (parameters DATA_W, NUM_SRC); the skid buffer SHALL stay in fwd_mux_pipe.

Verification
REQ-031 SHALL cover passthrough: NUM_SRC=3, in_data={C,B,A}, in_sel=2, out_ready=1 → out_data=C one cycle later, sustaining 1/cycle.
REQ-032 SHALL cover backpressure: out_ready=0, push 0x11 then 0x22 → in_ready=0 after the second push; out_ready=1 → 0x11 then 0x22 emerge in order.
REQ-033 SHALL cover the out-of-range select: NUM_SRC=3, in_sel=3 → out_data=source 0; sel_err=1 only if FWD_MUX_SEL_ERR_EN is defined.
REQ-034 SHALL cover flush: in state TWO assert flush together with in_valid → out_valid=0 and in_ready=1 the next cycle, with the pushed data discarded.
REQ-035 SHALL cover asynchronous reset: assert rst_n=0 between edges while in state ONE → out_valid=0 immediately; first post-reset push of 0xDEADBEEF emerges intact.
REQ-036 SHALL cover parameter sweep: DATA_W=64, NUM_SRC=5, in_sel=4 → correct 64-bit source 4; NUM_SRC=2 with SEL_W=1 passes REQ-031.
